// File: rtl/ripple_cap_pkg.sv
// Shared constants and FSM state type for the ripple counter capture block.
package ripple_cap_pkg;

    localparam int unsigned W_DEF             = 4;
    localparam int unsigned STABLE_CYCLES_DEF = 2;
    localparam int unsigned EXT_W_DEF         = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SETTLE  = 2'b01,
        PRESENT = 2'b10
    } cap_state_t;

endpackage

// File: rtl/ripple_count_capture_if.sv
// Capture output bus: valid/ready count handshake plus wrap/overrun status.
// cnt_ext exists only when RIPPLE_EXT_EN is defined.
interface ripple_count_capture_if
#(
    parameter int unsigned W     = 4
`ifdef RIPPLE_EXT_EN
    ,
    parameter int unsigned EXT_W = 8
`endif
);

    logic         cnt_valid;
    logic [W-1:0] cnt_data;
    logic         cnt_ready;
    logic         wrap_pulse;
    logic         overrun;
    logic         clr_ovr;

`ifdef RIPPLE_EXT_EN
    logic [EXT_W-1:0] cnt_ext;

    modport master (
        output cnt_valid, cnt_data, wrap_pulse, overrun, cnt_ext,
        input  cnt_ready, clr_ovr
    );

    modport slave (
        input  cnt_valid, cnt_data, wrap_pulse, overrun, cnt_ext,
        output cnt_ready, clr_ovr
    );
`else
    modport master (
        output cnt_valid, cnt_data, wrap_pulse, overrun,
        input  cnt_ready, clr_ovr
    );

    modport slave (
        input  cnt_valid, cnt_data, wrap_pulse, overrun,
        output cnt_ready, clr_ovr
    );
`endif

endinterface

// File: rtl/sync_2ff.sv
// Vector two-flop synchroniser with synchronous active-low reset; exposes both stages.
module sync_2ff #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] s1,
    output logic [W-1:0] s2
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= d;
            s2 <= s1;
        end
    end

endmodule

// File: rtl/ripple_count_capture.sv
// Brings an asynchronous ripple count into clk: sync, settle filter, change capture, wrap detect.
// Define RIPPLE_EXT_EN to add the wrap-extension counter cnt_ext.
module ripple_count_capture
    import ripple_cap_pkg::*;
#(
    parameter int unsigned W             = W_DEF,
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF
`ifdef RIPPLE_EXT_EN
    ,
    parameter int unsigned EXT_W         = EXT_W_DEF
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [W-1:0]           cnt_in,
    input  logic                   sample_en,
    ripple_count_capture_if.master bus
);

    localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);

    logic [W-1:0]  s1;
    logic [W-1:0]  s2;
    logic [SW-1:0] stab_cnt;
    logic          settled;

    cap_state_t    state;
    cap_state_t    state_nxt;
    logic          valid_q;
    logic          valid_nxt;
    logic [W-1:0]  data_q;
    logic [W-1:0]  data_nxt;
    logic [W-1:0]  prev_q;
    logic [W-1:0]  prev_nxt;
    logic          have_q;
    logic          have_nxt;
    logic          wrap_q;
    logic          wrap_nxt;
    logic          ovr_q;
    logic          ovr_nxt;
`ifdef RIPPLE_EXT_EN
    logic [EXT_W-1:0] ext_q;
    logic [EXT_W-1:0] ext_nxt;
`endif

    sync_2ff #(.W(W)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (cnt_in),
        .s1  (s1),
        .s2  (s2)
    );

    // Settle filter: s1 is the value about to enter s2, so s1==s2 means s2 holds steady.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stab_cnt <= '0;
        end else if (s1 != s2) begin
            stab_cnt <= '0;
        end else if (stab_cnt != STAB_MAX) begin
            stab_cnt <= stab_cnt + SW'(1);
        end
    end

    assign settled = (stab_cnt == STAB_MAX);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            data_q  <= '0;
            prev_q  <= '0;
            have_q  <= 1'b0;
            wrap_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef RIPPLE_EXT_EN
            ext_q   <= '0;
`endif
        end else begin
            state   <= state_nxt;
            valid_q <= valid_nxt;
            data_q  <= data_nxt;
            prev_q  <= prev_nxt;
            have_q  <= have_nxt;
            wrap_q  <= wrap_nxt;
            ovr_q   <= ovr_nxt;
`ifdef RIPPLE_EXT_EN
            ext_q   <= ext_nxt;
`endif
        end
    end

    // Next-state and registered-output logic; overrun set takes priority over clr_ovr.
    always_comb begin
        state_nxt = state;
        valid_nxt = valid_q;
        data_nxt  = data_q;
        prev_nxt  = prev_q;
        have_nxt  = have_q;
        wrap_nxt  = 1'b0;
        ovr_nxt   = ovr_q;
`ifdef RIPPLE_EXT_EN
        ext_nxt   = ext_q;
`endif

        if (bus.clr_ovr) begin
            ovr_nxt = 1'b0;
        end

        unique case (state)
            IDLE: begin
                if (sample_en) begin
                    state_nxt = SETTLE;
                end
            end

            SETTLE: begin
                if (!sample_en) begin
                    state_nxt = IDLE;
                end else if (settled && ((s2 != prev_q) || !have_q)) begin
                    data_nxt  = s2;
                    prev_nxt  = s2;
                    have_nxt  = 1'b1;
                    valid_nxt = 1'b1;
                    state_nxt = PRESENT;
                    if (have_q && (s2 < prev_q)) begin
                        wrap_nxt = 1'b1;
`ifdef RIPPLE_EXT_EN
                        ext_nxt  = ext_q + EXT_W'(1);
`endif
                    end
                end
            end

            PRESENT: begin
                if (bus.cnt_ready) begin
                    valid_nxt = 1'b0;
                    state_nxt = sample_en ? SETTLE : IDLE;
                end else if (settled && (s2 != data_q)) begin
                    ovr_nxt = 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
            end
        endcase
    end

    assign bus.cnt_valid  = valid_q;
    assign bus.cnt_data   = data_q;
    assign bus.wrap_pulse = wrap_q;
    assign bus.overrun    = ovr_q;
`ifdef RIPPLE_EXT_EN
    assign bus.cnt_ext    = ext_q;
`endif

endmodule
